subtractor_serial: RTL and testbench

Bit-serial unsigned subtractor that computes `a - b - borrow_in` one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It is the inverse-direction companion of the ripple adder datapath: it trades area for latency in area-constrained arithmetic paths. Operands enter through a valid/ready start handshake, and the result leaves through a valid/ready result handshake.

---
 rtl/subtractor_serial_pkg.sv | 5 +
 rtl/subtractor_bit.sv | 11 +
 rtl/subtractor_serial.sv | 84 ++++++++
 tb/tb_subtractor_serial.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/subtractor_serial_pkg.sv
// subtractor_serial_pkg: shared FSM encoding and default width for the serial subtractor
package subtractor_serial_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/subtractor_bit.sv
// subtractor_bit: combinational full subtractor cell, companion of adder_bit
module subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);
  assign diff = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// File: rtl/subtractor_serial.sv
// subtractor_serial: LSB-first bit-serial a-b-borrow_in; overflow port under SUBTRACTOR_SERIAL_OVERFLOW_EN
module subtractor_serial
  import subtractor_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic br, d, bo, last;
  assign last = cnt == CW'(WIDTH - 1);
  assign borrow_out = br;
  subtractor_bit u_bit (
    .a(a_sr[0]),
    .b(b_sr[0]),
    .borrow_in(br),
    .diff(d),
    .borrow_out(bo)
  );
  // FSM, operand shifters, borrow flop and result register; the operand LSBs hold the original MSBs on the last RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      start_ready <= 1'b1;
      result_valid <= 1'b0;
      diff <= '0;
      br <= 1'b0;
      cnt <= '0;
      a_sr <= '0;
      b_sr <= '0;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a_sr <= a;
          b_sr <= b;
          br <= borrow_in;
          cnt <= '0;
          state <= RUN;
          start_ready <= 1'b0;
        end
        RUN: begin
          diff <= {d, diff[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br <= bo;
          cnt <= last ? cnt : cnt + CW'(1);
          if (last) begin
            state <= DONE;
            result_valid <= 1'b1;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            overflow <= (a_sr[0] ^ b_sr[0]) & (d ^ a_sr[0]);
`endif
          end
        end
        DONE: if (result_ready) begin
          state <= IDLE;
          result_valid <= 1'b0;
          start_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subtractor_serial.sv
// tb_subtractor_serial: directed and exhaustive checks of the serial subtractor at WIDTH=8 and WIDTH=4
module tb_subtractor_serial;
  logic clk = 1'b0, rst = 1'b1;
  logic sv8 = 1'b0, sr8, bi8 = 1'b0, rv8, rr8 = 1'b0, bo8;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic sv4 = 1'b0, sr4, bi4 = 1'b0, rv4, rr4 = 1'b0, bo4;
  logic [3:0] a4 = '0, b4 = '0, d4;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
  logic ov8, ov4;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  subtractor_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8),
    .borrow_in(bi8), .result_valid(rv8), .result_ready(rr8), .diff(d8), .borrow_out(bo8)
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    , .overflow(ov8)
`endif
  );

  subtractor_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start_valid(sv4), .start_ready(sr4), .a(a4), .b(b4),
    .borrow_in(bi4), .result_valid(rv4), .result_ready(rr4), .diff(d4), .borrow_out(bo4)
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    , .overflow(ov4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi, output int lat);
    chk("ready8", 32'(sr8), 32'd1);
    a8 = a; b8 = b; bi8 = bi; sv8 = 1'b1;
    step();
    sv8 = 1'b0; a8 = ~a; b8 = ~b; bi8 = ~bi;
    lat = 0;
    while (!rv8 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic consume8;
    rr8 = 1'b1;
    step();
    rr8 = 1'b0;
    chk("ready_after_consume", 32'(sr8), 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] hold_d;
    logic [4:0] ref4;
    step();
    step();
    chk("rst_start_ready", 32'(sr8), 32'd1);
    chk("rst_result_valid", 32'(rv8), 32'd0);
    chk("rst_diff", 32'(d8), 32'h00);
    chk("rst_borrow", 32'(bo8), 32'd0);
    rst = 1'b0;
    step();
    run8(8'h05, 8'h03, 1'b0, lat);
    chk("lat_5_3", 32'(lat), 32'd8);
    chk("diff_5_3", 32'(d8), 32'h02);
    chk("borrow_5_3", 32'(bo8), 32'd0);
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    chk("ovf_5_3", 32'(ov8), 32'd0);
`endif
    consume8();
    run8(8'h00, 8'h01, 1'b0, lat);
    chk("lat_0_1", 32'(lat), 32'd8);
    chk("diff_0_1", 32'(d8), 32'hFF);
    chk("borrow_0_1", 32'(bo8), 32'd1);
    consume8();
    run8(8'h10, 8'h10, 1'b1, lat);
    chk("diff_10_10_b", 32'(d8), 32'hFF);
    chk("borrow_10_10_b", 32'(bo8), 32'd1);
    consume8();
    run8(8'h80, 8'h01, 1'b0, lat);
    chk("diff_80_1", 32'(d8), 32'h7F);
    chk("borrow_80_1", 32'(bo8), 32'd0);
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    chk("ovf_80_1", 32'(ov8), 32'd1);
`endif
    hold_d = d8;
    a8 = 8'h33; b8 = 8'h11; sv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(rv8), 32'd1);
      chk("bp_diff", 32'(d8), 32'(hold_d));
      chk("bp_ready", 32'(sr8), 32'd0);
    end
    rr8 = 1'b1;
    step();
    sv8 = 1'b0; rr8 = 1'b0;
    chk("bp_release_ready", 32'(sr8), 32'd1);
    chk("bp_release_valid", 32'(rv8), 32'd0);
    step();
    chk("bp_start_ignored", 32'(sr8), 32'd1);
    a8 = 8'h5A; b8 = 8'h0F; bi8 = 1'b0; sv8 = 1'b1;
    step();
    sv8 = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun_ready", 32'(sr8), 32'd1);
    chk("midrun_valid", 32'(rv8), 32'd0);
    chk("midrun_diff", 32'(d8), 32'h00);
    chk("midrun_borrow", 32'(bo8), 32'd0);
    run8(8'hFF, 8'hFE, 1'b0, lat);
    chk("lat_ff_fe", 32'(lat), 32'd8);
    chk("diff_ff_fe", 32'(d8), 32'h01);
    chk("borrow_ff_fe", 32'(bo8), 32'd0);
    consume8();
    for (int i = 0; i < 512; i++) begin
      a4 = 4'(i >> 5); b4 = 4'(i >> 1); bi4 = i[0]; sv4 = 1'b1;
      ref4 = {1'b0, a4} - {1'b0, b4} - {4'b0, bi4};
      step();
      sv4 = 1'b0;
      lat = 0;
      while (!rv4 && lat < 12) begin
        step();
        lat++;
      end
      chk("exh4", 32'({bo4, d4}), 32'(ref4));
      rr4 = 1'b1;
      step();
      rr4 = 1'b0;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
